// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, IF/ID record and
// the default reset vector / bubble instruction.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] DEF_NOP_INSTR    = 32'h00000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry skid buffer for fetched instructions that arrive while IF/ID is
// held, plus the pending-redirect register for branches raised while the PC
// is frozen. push/pop and set/clear are mutually exclusive by construction
// in the parent.
module fetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic        pop,
  output logic        buf_valid,
  output logic [31:0] buf_instr,
  input  logic        redir_set,
  input  logic [31:0] redir_target,
  input  logic        redir_clear,
  output logic        pend_valid,
  output logic [31:0] pend_target
);

  // Skid entry: filled by a response IF/ID could not take, drained first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_instr <= '0;
    end else if (push) begin
      buf_valid <= 1'b1;
      buf_instr <= push_instr;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end

  // Pending redirect: newest target wins, consumed by the next PC update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (redir_clear) begin
      pend_valid  <= 1'b0;
    end else if (redir_set) begin
      pend_valid  <= 1'b1;
      pend_target <= redir_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: PC, memory-request FSM and IF/ID register.
// Optional macro FETCH_HALT_ON_ZERO_EN: a launch toward address 0 halts the
// CPU (HALTED, active=0) instead of fetching; without it address 0 is
// fetched normally and active is tied high.
// The hazard unit is expected to assert PCWrite together with IF_ID_Write;
// an instruction entering IF/ID with PCWrite=0 leaves the PC in place, so
// the same address is fetched again.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        FetchMemSel,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        fetch_valid,
  output logic        active
);

  fetch_state_e state, state_nx;
  logic [31:0]  pc, pc_nx, pc_plus4;
  if_id_t       ifid;
  logic         accept, avail, enter, pc_upd, launch;
  logic [31:0]  avail_data;
  logic         buf_valid, pend_valid;
  logic [31:0]  buf_instr, pend_target;

  // mem_read is decoded from state so an async reset drops it at once.
  assign mem_read    = (state == ST_REQ) || (state == ST_WAIT);
  assign mem_address = pc;
  assign accept      = mem_read && !mem_waitrequest;

  // The buffered word is always older than anything in flight.
  assign avail      = buf_valid || accept;
  assign avail_data = buf_valid ? buf_instr : mem_readdata;
  assign enter      = IF_ID_Write && avail;
  assign pc_upd     = enter && PCWrite;
  assign pc_plus4   = pc + 32'd4;

  fetch_buffer u_buf (
    .clk          (clk),
    .reset        (reset),
    .push         (accept && !IF_ID_Write),
    .push_instr   (mem_readdata),
    .pop          (buf_valid && IF_ID_Write),
    .buf_valid    (buf_valid),
    .buf_instr    (buf_instr),
    .redir_set    (branch_taken && !pc_upd),
    .redir_target (branch_target),
    .redir_clear  (pc_upd),
    .pend_valid   (pend_valid),
    .pend_target  (pend_target)
  );

  // Next PC: a live branch beats a pending one, otherwise sequential.
  always_comb begin
    pc_nx = pc;
    if (pc_upd) begin
      if (branch_taken)    pc_nx = branch_target;
      else if (pend_valid) pc_nx = pend_target;
      else                 pc_nx = pc_plus4;
    end
  end

  // Launch a new request: from IDLE with an empty buffer, or back-to-back on
  // an accept that goes straight into IF/ID (keeps one fetch per cycle).
  always_comb begin
    launch = 1'b0;
    case (state)
      ST_IDLE:         launch = FetchMemSel && !buf_valid;
      ST_REQ, ST_WAIT: launch = accept && IF_ID_Write && FetchMemSel;
      default:         launch = 1'b0;
    endcase
  end

  // FSM next state; an in-flight request ignores FetchMemSel until accepted.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:         if (launch) state_nx = ST_REQ;
      ST_REQ, ST_WAIT: state_nx = accept ? (launch ? ST_REQ : ST_IDLE) : ST_WAIT;
`ifdef FETCH_HALT_ON_ZERO_EN
      ST_HALTED:       state_nx = ST_HALTED;
`endif
      default:         state_nx = ST_IDLE;
    endcase
`ifdef FETCH_HALT_ON_ZERO_EN
    if (launch && (pc_nx == 32'd0)) state_nx = ST_HALTED;
`endif
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  assign active = (state != ST_HALTED);
`else
  assign active = 1'b1;
`endif

  // State and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // IF/ID: real instruction when one is available, else a bubble; holds
  // while IF_ID_Write=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid.instr    <= NOP_INSTR;
      ifid.pc       <= '0;
      ifid.pc_plus4 <= '0;
      ifid.valid    <= 1'b0;
    end else if (IF_ID_Write) begin
      if (avail) begin
        ifid.instr    <= avail_data;
        ifid.pc       <= pc;
        ifid.pc_plus4 <= pc_plus4;
        ifid.valid    <= 1'b1;
      end else begin
        ifid.instr    <= NOP_INSTR;
        ifid.valid    <= 1'b0;
      end
    end
  end

  assign IF_ID_Instruction = ifid.instr;
  assign IF_ID_PC          = ifid.pc;
  assign IF_ID_PC_plus4    = ifid.pc_plus4;
  assign fetch_valid       = ifid.valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000000, meaning the bubble instruction driven into IF/ID.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port PCWrite, input, 1 bit: PC update permitted (from hazard unit).
REQ-007 SHALL have port IF_ID_Write, input, 1 bit: IF/ID register load permitted.
REQ-008 SHALL have port FetchMemSel, input, 1 bit: 1 means fetch owns the memory port, 0 means the data access owns it.
REQ-009 SHALL have port branch_taken, input, 1 bit: the ID stage requests a redirect.
REQ-010 SHALL have port branch_target, input, 32 bits: the redirect address.
REQ-011 SHALL have ports mem_address (output, 32), mem_read (output, 1), mem_waitrequest (input, 1) and mem_readdata (input, 32): the instruction-side memory request.
REQ-012 SHALL have ports IF_ID_Instruction (output, 32), IF_ID_PC (output, 32) and IF_ID_PC_plus4 (output, 32): the IF/ID register contents.
REQ-013 SHALL have port fetch_valid, output, 1 bit: the IF/ID register holds a real fetched instruction.
REQ-014 SHALL have port active, output, 1 bit: the CPU has not halted.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT, HALTED.
REQ-016 SHALL behave as follows in IDLE: when FetchMemSel=1 and the skid buffer is empty, go to REQ.
REQ-017 SHALL behave as follows in REQ/WAIT: mem_read=1 and mem_address=pc; stay in WAIT while mem_waitrequest=1.
REQ-018 SHALL treat a response as accepted on any edge with mem_read=1 and mem_waitrequest=0.
REQ-019 SHALL continue an in-flight request until accepted, independent of FetchMemSel; FetchMemSel is sampled only when a request is launched.
REQ-020 SHALL handle an accepted response with IF_ID_Write=1 and an empty buffer by loading it straight into IF/ID that edge (zero bubble) and setting fetch_valid=1.
REQ-021 SHALL handle an accepted response with IF_ID_Write=0 by writing it to the one-entry skid buffer; no new request is launched while the buffer is full.
REQ-022 SHALL drain the buffer into IF/ID, before any new data, at the first edge with IF_ID_Write=1.
REQ-023 SHALL, on an IF_ID_Write=1 edge with no instruction available, load IF_ID_Instruction=NOP_INSTR with fetch_valid=0; while IF_ID_Write=0, IF/ID holds.
REQ-024 SHALL update the PC only at edges with PCWrite=1 where an instruction enters IF/ID, to pc+4 (mod 2^32) or to the redirect address.
REQ-025 SHALL latch branch_taken/branch_target into a pending redirect if they arrive while the PC cannot update; the redirect applies at the next PC update, then clears.
REQ-026 SHALL take the newer branch_target when a new branch_taken coincides with a pending redirect.
REQ-027 SHALL keep the delay slot: the instruction already fetched or in flight when a redirect is raised is delivered, never squashed.
REQ-028 SHALL sustain throughput of one instruction per cycle when mem_waitrequest=0, FetchMemSel=1 and no stalls.

Reset
REQ-029 SHALL apply these values on reset assertion: pc=RESET_VECTOR, state IDLE, mem_read=0, buffer empty, pending redirect cleared, IF_ID_Instruction=NOP_INSTR, IF_ID_PC=0, IF_ID_PC_plus4=0, fetch_valid=0, active=1.
REQ-030 SHALL, on reset mid-request, drop mem_read immediately (asynchronous) and discard the outstanding response.

Configuration
REQ-031 SHALL support macro FETCH_HALT_ON_ZERO_EN.
REQ-032 SHALL, when FETCH_HALT_ON_ZERO_EN is defined, enter HALTED instead of REQ for a launch with pc==0; in HALTED, active=0, mem_read=0, bubbles are loaded on IF_ID_Write, and exit is by reset only.
REQ-033 SHALL, when FETCH_HALT_ON_ZERO_EN is undefined, fetch address 0 normally, omit the HALTED state and tie active to 1.

Structure
REQ-034 SHALL place the fetch state enum, RESET_VECTOR and NOP_INSTR default constants in shared package mips_pkg.
REQ-035 SHALL implement the skid buffer and pending-redirect register as one sub-module, fetch_buffer; the FSM and PC stay in fetch_stage.

Verification
REQ-036 SHALL cover: reset, then waitrequest=0 and no stalls -> mem_address sequence BFC00000, BFC00004, BFC00008, with fetch_valid=1 from the second edge.
REQ-037 SHALL cover: waitrequest held 3 cycles on the first fetch -> mem_read stays 1 and address stable; IF/ID receives the data on the accepting edge.
REQ-038 SHALL cover: response accepted while IF_ID_Write=0 for 2 cycles -> buffered, no new request, IF/ID loaded on release, nothing lost or duplicated.
REQ-039 SHALL cover: branch_taken target 0xBFC00100 during a PCWrite=0 stall -> the delay-slot instruction is delivered, then the next address is BFC00100.
REQ-040 SHALL cover: FetchMemSel=0 for 2 cycles while IDLE -> no mem_read and bubbles with fetch_valid=0; FetchMemSel=0 during WAIT -> the request completes.
REQ-041 SHALL cover: with FETCH_HALT_ON_ZERO_EN, a jump to 0 -> active=0, no read at 0; without the macro -> a read at 0 occurs.
